// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback unit.
//   XLEN     : datapath width
//   REG_AW   : register index width
//   wb_src_t : which source feeds the output stage this cycle
//   wb_req_t : one pending register write (index, value, CSR flag)
package wb_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    BUF  = 2'd1,
    EX   = 2'd2,
    LD   = 2'd3
  } wb_src_t;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
    logic              csr;
  } wb_req_t;

endpackage

// File: rtl/writeback_unit_if.sv
// Handshake bundle between the execute / load-store stages and the
// writeback unit.
//   ex_valid/ex_ready/ex_rd/ex_result/ex_csr : execute result channel
//   ld_valid/ld_ready/ld_rd/ld_data          : load response channel
// master = producer side (execute + LSU), slave = writeback unit.
interface writeback_unit_if #(
  parameter int XLEN = 32
) ();

  logic            ex_valid;
  logic            ex_ready;
  logic [4:0]      ex_rd;
  logic [XLEN-1:0] ex_result;
  logic            ex_csr;

  logic            ld_valid;
  logic            ld_ready;
  logic [4:0]      ld_rd;
  logic [XLEN-1:0] ld_data;

  modport master (
    output ex_valid, ex_rd, ex_result, ex_csr,
    input  ex_ready,
    output ld_valid, ld_rd, ld_data,
    input  ld_ready
  );

  modport slave (
    input  ex_valid, ex_rd, ex_result, ex_csr,
    output ex_ready,
    input  ld_valid, ld_rd, ld_data,
    output ld_ready
  );

endinterface

// File: rtl/wb_scoreboard.sv
// Busy-bit scoreboard of destination registers with outstanding loads.
//   clk, rst        : clock, synchronous active-high reset
//   iss_load_i/rd_i : a load is issuing; marks its destination busy
//   clr_valid_i/rd_i: a load result enters the output stage; clears busy
//   dec_rs1/rs2/rd_i: decode-stage indices to look up
//   dec_hazard_o    : any looked-up index is busy (x0 never busy)
module wb_scoreboard #(
  parameter int NREGS  = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_load_i,
  input  logic [REG_AW-1:0] iss_rd_i,
  input  logic              clr_valid_i,
  input  logic [REG_AW-1:0] clr_rd_i,
  input  logic [REG_AW-1:0] dec_rs1_i,
  input  logic [REG_AW-1:0] dec_rs2_i,
  input  logic [REG_AW-1:0] dec_rd_i,
  output logic              dec_hazard_o
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Next busy vector: clear first so a same-index set (newer load) wins.
  always_comb begin
    busy_d = busy_q;
    if (clr_valid_i) begin
      busy_d[clr_rd_i] = 1'b0;
    end else begin
      busy_d = busy_d;
    end
    if (iss_load_i && (iss_rd_i != '0)) begin
      busy_d[iss_rd_i] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
  end

  // Busy-bit register.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Hazard lookup; x0 is masked because it is never a real dependency.
  always_comb begin
    dec_hazard_o = ((dec_rs1_i != '0) && busy_q[dec_rs1_i]) |
                   ((dec_rs2_i != '0) && busy_q[dec_rs2_i]) |
                   ((dec_rd_i  != '0) && busy_q[dec_rd_i]);
  end

endmodule

// File: rtl/writeback_unit.sv
// Writeback arbiter owning the register file write port.
// Merges execute results and load responses into one registered write
// stream; a load colliding with an execute result is parked in a
// one-entry buffer and written the following cycle.
//   clk, rst              : clock, synchronous active-high reset
//   wb (slave)            : execute / load handshake channels
//   iss_load, iss_rd      : issuing load, marks destination busy
//   dec_rs1/rs2/rd        : decode indices; dec_hazard = stall request
//   reg_write, csr_write_enable, rd, result : registered regfile write
// Optional feature macro: WB_SCOREBOARD_EN compiles in the busy-bit
// scoreboard; without it dec_hazard is tied low.
module writeback_unit #(
  parameter int XLEN  = wb_pkg::XLEN,
  parameter int NREGS = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  writeback_unit_if.slave           wb,
  input  logic                      iss_load,
  input  logic [wb_pkg::REG_AW-1:0] iss_rd,
  input  logic [wb_pkg::REG_AW-1:0] dec_rs1,
  input  logic [wb_pkg::REG_AW-1:0] dec_rs2,
  input  logic [wb_pkg::REG_AW-1:0] dec_rd,
  output logic                      dec_hazard,
  output logic                      reg_write,
  output logic                      csr_write_enable,
  output logic [wb_pkg::REG_AW-1:0] rd,
  output logic [XLEN-1:0]           result
);

  import wb_pkg::*;

  wb_src_t           src_s;
  wb_req_t           sel_s;
  wb_req_t           buf_q, buf_d;
  logic              buf_full_q, buf_full_d;
  logic              reg_write_q, reg_write_d;
  logic              csr_we_q, csr_we_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              clr_valid_s;
  logic [REG_AW-1:0] clr_rd_s;

  // Both inputs stall while the buffer drains.
  assign wb.ex_ready = ~buf_full_q;
  assign wb.ld_ready = ~buf_full_q;

  // Source priority: buffered load, execute result, fresh load.
  always_comb begin
    src_s = NONE;
    if (buf_full_q) begin
      src_s = BUF;
    end else if (wb.ex_valid) begin
      src_s = EX;
    end else if (wb.ld_valid) begin
      src_s = LD;
    end else begin
      src_s = NONE;
    end
  end

  // Selected request for the output stage.
  always_comb begin
    sel_s = '{rd: '0, data: '0, csr: 1'b0};
    case (src_s)
      BUF:     sel_s = buf_q;
      EX:      sel_s = '{rd: wb.ex_rd, data: wb.ex_result, csr: wb.ex_csr};
      LD:      sel_s = '{rd: wb.ld_rd, data: wb.ld_data, csr: 1'b0};
      default: sel_s = '{rd: '0, data: '0, csr: 1'b0};
    endcase
  end

  // Next-state for buffer and output stage.
  always_comb begin
    buf_d      = buf_q;
    buf_full_d = 1'b0;
    if (!buf_full_q && wb.ex_valid && wb.ld_valid) begin
      // Execute wins the collision; park the load for next cycle.
      buf_full_d = 1'b1;
      buf_d      = '{rd: wb.ld_rd, data: wb.ld_data, csr: 1'b0};
    end else begin
      buf_full_d = 1'b0;
    end

    reg_write_d = (src_s != NONE) && !sel_s.csr;
    csr_we_d    = (src_s != NONE) && sel_s.csr;
    if (src_s != NONE) begin
      rd_d     = sel_s.rd;
      result_d = sel_s.data;
    end else begin
      rd_d     = rd_q;
      result_d = result_q;
    end

    clr_valid_s = (src_s == BUF) || (src_s == LD);
    clr_rd_s    = sel_s.rd;
  end

  // Buffer and output stage registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_full_q  <= 1'b0;
      buf_q       <= '{rd: '0, data: '0, csr: 1'b0};
      reg_write_q <= 1'b0;
      csr_we_q    <= 1'b0;
      rd_q        <= '0;
      result_q    <= '0;
    end else begin
      buf_full_q  <= buf_full_d;
      buf_q       <= buf_d;
      reg_write_q <= reg_write_d;
      csr_we_q    <= csr_we_d;
      rd_q        <= rd_d;
      result_q    <= result_d;
    end
  end

  assign reg_write        = reg_write_q;
  assign csr_write_enable = csr_we_q;
  assign rd               = rd_q;
  assign result           = result_q;

`ifdef WB_SCOREBOARD_EN
  wb_scoreboard #(
    .NREGS  (NREGS),
    .REG_AW (REG_AW)
  ) u_scoreboard (
    .clk          (clk),
    .rst          (rst),
    .iss_load_i   (iss_load),
    .iss_rd_i     (iss_rd),
    .clr_valid_i  (clr_valid_s),
    .clr_rd_i     (clr_rd_s),
    .dec_rs1_i    (dec_rs1),
    .dec_rs2_i    (dec_rs2),
    .dec_rd_i     (dec_rd),
    .dec_hazard_o (dec_hazard)
  );
`else
  // Interlocking is left to decode; these inputs have no effect.
  logic unused_sb_s;
  assign unused_sb_s = ^{iss_load, iss_rd, dec_rs1, dec_rs2, dec_rd,
                         clr_valid_s, clr_rd_s};
  assign dec_hazard  = 1'b0;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: stimulus pushes expected writes,
// a negedge monitor pops and compares every write strobe.
module tb_writeback_unit;

`ifdef WB_SCOREBOARD_EN
  localparam logic SB = 1'b1;
`else
  localparam logic SB = 1'b0;
`endif

  typedef struct {
    logic        rw;
    logic        csr;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        iss_load;
  logic [4:0]  iss_rd;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic        dec_hazard;
  logic        reg_write;
  logic        csr_write_enable;
  logic [4:0]  rd;
  logic [31:0] result;

  int   n_tests;
  int   n_fail;
  exp_t exp_q[$];
  exp_t mon_e;

  writeback_unit_if #(.XLEN(32)) wb_if ();

  writeback_unit #(.XLEN(32), .NREGS(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .wb               (wb_if),
    .iss_load         (iss_load),
    .iss_rd           (iss_rd),
    .dec_rs1          (dec_rs1),
    .dec_rs2          (dec_rs2),
    .dec_rd           (dec_rd),
    .dec_hazard       (dec_hazard),
    .reg_write        (reg_write),
    .csr_write_enable (csr_write_enable),
    .rd               (rd),
    .result           (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic push(input logic rw, input logic csr, input logic [4:0] r, input logic [31:0] d);
    exp_t e;
    e.rw = rw; e.csr = csr; e.rd = r; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic drive_ex(input logic [4:0] r, input logic [31:0] d, input logic csr);
    wb_if.ex_valid  = 1'b1;
    wb_if.ex_rd     = r;
    wb_if.ex_result = d;
    wb_if.ex_csr    = csr;
  endtask

  task automatic drive_ld(input logic [4:0] r, input logic [31:0] d);
    wb_if.ld_valid = 1'b1;
    wb_if.ld_rd    = r;
    wb_if.ld_data  = d;
  endtask

  task automatic idle();
    wb_if.ex_valid = 1'b0;
    wb_if.ex_csr   = 1'b0;
    wb_if.ld_valid = 1'b0;
    iss_load       = 1'b0;
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (reg_write === 1'b1 || csr_write_enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got rd=%0d result=0x%0h, expected no write", rd, result);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wb_reg_write", {31'd0, reg_write}, {31'd0, mon_e.rw});
        chk("wb_csr_we", {31'd0, csr_write_enable}, {31'd0, mon_e.csr});
        chk("wb_rd", {27'd0, rd}, {27'd0, mon_e.rd});
        chk("wb_result", result, mon_e.data);
      end
    end
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    wb_if.ex_valid = 1'b0; wb_if.ex_rd = 5'd0; wb_if.ex_result = 32'd0; wb_if.ex_csr = 1'b0;
    wb_if.ld_valid = 1'b0; wb_if.ld_rd = 5'd0; wb_if.ld_data = 32'd0;
    iss_load = 1'b0; iss_rd = 5'd0;
    dec_rs1 = 5'd0; dec_rs2 = 5'd0; dec_rd = 5'd0;

    repeat (2) tick();
    rst = 1'b0;
    settle();
    // Reset state
    chk("rst_reg_write", {31'd0, reg_write}, 32'd0);
    chk("rst_csr_we", {31'd0, csr_write_enable}, 32'd0);
    chk("rst_rd", {27'd0, rd}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_ex_ready", {31'd0, wb_if.ex_ready}, 32'd1);
    chk("rst_ld_ready", {31'd0, wb_if.ld_ready}, 32'd1);
    chk("rst_hazard", {31'd0, dec_hazard}, 32'd0);

    // Plain execute write
    tick();
    drive_ex(5'd5, 32'h12345678, 1'b0);
    push(1'b1, 1'b0, 5'd5, 32'h12345678);
    settle();
    chk("ex_ready_idle", {31'd0, wb_if.ex_ready}, 32'd1);
    tick();
    idle();

    // Collision: execute first, load buffered one cycle
    tick();
    drive_ex(5'd3, 32'hAAAA0000, 1'b0);
    drive_ld(5'd4, 32'h0000BBBB);
    push(1'b1, 1'b0, 5'd3, 32'hAAAA0000);
    push(1'b1, 1'b0, 5'd4, 32'h0000BBBB);
    tick();
    idle();
    settle();
    chk("coll_ex_ready_low", {31'd0, wb_if.ex_ready}, 32'd0);
    chk("coll_ld_ready_low", {31'd0, wb_if.ld_ready}, 32'd0);
    tick();
    settle();
    chk("coll_ex_ready_back", {31'd0, wb_if.ex_ready}, 32'd1);
    chk("coll_ld_ready_back", {31'd0, wb_if.ld_ready}, 32'd1);

    // CSR-sourced result, then an x0 result forwarded unchanged
    tick();
    drive_ex(5'd7, 32'h00001800, 1'b1);
    push(1'b0, 1'b1, 5'd7, 32'h00001800);
    tick();
    drive_ex(5'd0, 32'h5A5A5A5A, 1'b0);
    push(1'b1, 1'b0, 5'd0, 32'h5A5A5A5A);
    tick();
    idle();

    // Read-after-load hazard on x9, cleared by a fresh load result
    tick();
    iss_load = 1'b1; iss_rd = 5'd9;
    tick();
    iss_load = 1'b0;
    dec_rs2 = 5'd9;
    settle();
    chk("haz_set", {31'd0, dec_hazard}, {31'd0, SB});
    tick();
    drive_ld(5'd9, 32'hCAFEF00D);
    push(1'b1, 1'b0, 5'd9, 32'hCAFEF00D);
    settle();
    chk("haz_hold", {31'd0, dec_hazard}, {31'd0, SB});
    tick();
    idle();
    settle();
    chk("haz_clear", {31'd0, dec_hazard}, 32'd0);

    // Same-cycle completion and re-issue on x9: set wins
    tick();
    iss_load = 1'b1; iss_rd = 5'd9;
    tick();
    iss_load = 1'b1; iss_rd = 5'd9;
    drive_ld(5'd9, 32'h00000099);
    push(1'b1, 1'b0, 5'd9, 32'h00000099);
    tick();
    idle();
    settle();
    chk("haz_set_wins", {31'd0, dec_hazard}, {31'd0, SB});

    // Clear through the buffer path, looked up via dec_rd
    dec_rs2 = 5'd0;
    dec_rd  = 5'd9;
    settle();
    chk("haz_dec_rd", {31'd0, dec_hazard}, {31'd0, SB});
    tick();
    drive_ex(5'd1, 32'h00000011, 1'b0);
    drive_ld(5'd9, 32'h00000022);
    push(1'b1, 1'b0, 5'd1, 32'h00000011);
    push(1'b1, 1'b0, 5'd9, 32'h00000022);
    tick();
    idle();
    settle();
    chk("haz_buf_pending", {31'd0, dec_hazard}, {31'd0, SB});
    tick();
    settle();
    chk("haz_buf_clear", {31'd0, dec_hazard}, 32'd0);
    dec_rd = 5'd0;

    // x0 never busy
    tick();
    iss_load = 1'b1; iss_rd = 5'd0;
    tick();
    idle();
    settle();
    chk("haz_x0", {31'd0, dec_hazard}, 32'd0);

    // Collision followed by reset: buffered x4 must be discarded
    tick();
    iss_load = 1'b1; iss_rd = 5'd12;
    tick();
    idle();
    dec_rs1 = 5'd12;
    settle();
    chk("haz_pre_rst", {31'd0, dec_hazard}, {31'd0, SB});
    tick();
    drive_ex(5'd3, 32'hAAAA0000, 1'b0);
    drive_ld(5'd4, 32'h0000BBBB);
    push(1'b1, 1'b0, 5'd3, 32'hAAAA0000);
    tick();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    chk("post_rst_ex_ready", {31'd0, wb_if.ex_ready}, 32'd1);
    chk("post_rst_ld_ready", {31'd0, wb_if.ld_ready}, 32'd1);
    chk("post_rst_hazard", {31'd0, dec_hazard}, 32'd0);
    chk("post_rst_reg_write", {31'd0, reg_write}, 32'd0);
    chk("post_rst_rd", {27'd0, rd}, 32'd0);
    chk("post_rst_result", result, 32'd0);
    tick();
    settle();
    chk("post_rst_no_write", {31'd0, reg_write}, 32'd0);
    dec_rs1 = 5'd0;
    repeat (3) tick();

    chk("queue_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Single-port writeback arbiter that owns the register file's write port. It merges execute results (ALU and CSR reads) with variable-latency load responses into one registered `reg_write`/`rd`/`result` stream, and buffers a load that collides with an execute result. It also keeps a busy-bit scoreboard of destination registers with outstanding loads so decode can stall on read-after-load and write-after-load hazards. It sits between the execute/load-store stages and the register file.

## Interface
Parameters:
- `XLEN`, 32, datapath width.
- `NREGS`, 32, architectural integer registers; index width is log2(NREGS)=5.

Ports (clock and reset first):
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ex_valid`  in  1  execute result present this cycle.
- `ex_ready`  out  1  execute result accepted; equals `!buf_full`.
- `ex_rd`  in  5  execute destination.
- `ex_result`  in  XLEN  execute result value.
- `ex_csr`  in  1  result comes from a CSR read; drives `csr_write_enable`.
- `ld_valid`  in  1  load response present.
- `ld_ready`  out  1  load response accepted; equals `!buf_full`.
- `ld_rd`  in  5  load destination.
- `ld_data`  in  XLEN  load data, already extended.
- `iss_load`  in  1  a load is issuing this cycle; marks `iss_rd` busy.
- `iss_rd`  in  5  destination of the issuing load.
- `dec_rs1`, `dec_rs2`, `dec_rd`  in  5 each  decode-stage register indices.
- `dec_hazard`  out  1  decode must stall.
- `reg_write`  out  1  regfile write strobe.
- `csr_write_enable`  out  1  regfile write strobe for a CSR-sourced result.
- `rd`  out  5  regfile write index.
- `result`  out  XLEN  regfile write data.

## Operation
- Holds one output stage register (`reg_write`, `csr_write_enable`, `rd`, `result`) and one load buffer entry (`buf_full`, `buf_rd`, `buf_data`).
- Source priority for the output stage each cycle: buffered load, then execute result, then fresh load.
- A handshake on either input completes when `valid && ready` are high in the same cycle.
- If `buf_full` is set:
  - The buffer drains to the output stage and clears.
  - `ex_ready` and `ld_ready` are low.
- If `buf_full` is clear and `ex_valid` and `ld_valid` are both high:
  - The execute result goes to the output stage.
  - The load is captured into the buffer.
- If `buf_full` is clear and only one input is valid, that input goes straight to the output stage.
- If no source is selected, `reg_write` and `csr_write_enable` are 0. `rd` and `result` hold their previous values.
- Strobes for an accepted result:
  - `csr_write_enable` is set from `ex_csr` only for execute results.
  - `reg_write` is set for every accepted non-CSR result.
  - A result with rd=0 is forwarded unchanged. The regfile drops x0 writes, but the scoreboard still ignores x0.
- Scoreboard, 32 busy bits:
  - A bit is set on `iss_load` when `iss_rd != 0`.
  - A bit is cleared when a load result for that index enters the output stage, whether from the buffer or fresh.
  - If set and clear hit the same index in the same cycle, set wins, because a newer load is outstanding.
  - `dec_hazard` = busy[dec_rs1] | busy[dec_rs2] | busy[dec_rd], with index 0 always treated as not busy.
  - `dec_hazard` is combinational from the current busy bits. The regfile bypass covers the cycle the write strobe is high.

## Timing
- Reset values: `reg_write`=0, `csr_write_enable`=0, `rd`=0, `result`=0. `buf_full`=0, all busy bits 0, so `dec_hazard`=0.
- `ex_ready`=`ld_ready`=1 in the cycle after reset deasserts.
- Latency from input handshake to write strobe is 1 cycle. A buffered load takes 2 cycles.
- Throughput is one write per cycle. The buffer never holds more than 1 entry, and `ready` deasserts for exactly one cycle per collision.
- Reset asserted mid-operation discards the buffer, the output stage and the scoreboard. No write strobe is issued in the reset cycle or the cycle after it.

## Configuration
- `WB_SCOREBOARD_EN`
  - Defined: the busy-bit scoreboard and `dec_hazard` logic are compiled in as described above.
  - Undefined: there is no scoreboard state, `dec_hazard` is tied to 0, and `iss_load`, `iss_rd` and `dec_*` are ignored. Load-use interlocking is then the decode stage's responsibility.
- Arbitration and buffering are identical either way.

## Structure
- Shared package `wb_pkg`:
  - `XLEN` and `REG_AW`=5.
  - A source enum `wb_src_t` {NONE, BUF, EX, LD}.
  - A struct `wb_req_t` {rd, data, csr}.
- Sub-module `wb_scoreboard` holds the busy bits, the set/clear/priority logic and the hazard lookup. It is instantiated only under `WB_SCOREBOARD_EN`.

## Test plan
- Reset, then `ex_valid`, `ex_rd`=5, `ex_result`=0x12345678 → next cycle `reg_write`=1, `rd`=5, `result`=0x12345678.
- Same cycle: ex (rd=3, 0xAAAA0000) and ld (rd=4, 0x0000BBBB) → cycle+1 writes x3 with `ld_ready`=`ex_ready`=0; cycle+2 writes x4=0x0000BBBB; cycle+2 has ready=1.
- `ex_csr`=1, rd=7, 0x00001800 → `csr_write_enable`=1, `reg_write`=0, `rd`=7.
- `iss_load` rd=9, then `dec_rs2`=9 → `dec_hazard`=1 until the ld rd=9 result enters the output stage, then 0 (with macro). Without the macro, `dec_hazard` stays 0.
- Load on rd=9 completes while `iss_load` rd=9 in the same cycle → busy[9] stays 1.
- Collision as in test 2 with `rst` raised the next cycle → no write of x4, `buf_full`=0, all busy bits 0.
